// File: rtl/exibe_sequencia.sv
// exibe_sequencia: plays the stored colour sequence from a 16x4 synchronous ROM
// onto the LEDs. Each address from 0 to the latched limit is shown for T_ON
// cycles and then followed by T_OFF blank cycles. A one-cycle pronto pulse ends
// the run.
// Optional build macro PAUSA_JOGO_EN adds the congela input, which freezes the
// show/blank timing while it is high.
module exibe_sequencia #(
    parameter int T_ON  = 1000,
    parameter int T_OFF = 500,
    parameter int W     = 12
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] limite,
`ifdef PAUSA_JOGO_EN
    input  logic       congela,
`endif
    input  logic [3:0] dado,
    output logic [3:0] endereco,
    output logic [3:0] leds,
    output logic       ocupado,
    output logic       pronto,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        BUSCA   = 4'd1,
        CARREGA = 4'd2,
        MOSTRA  = 4'd3,
        PAUSA   = 4'd4,
        FIM     = 4'd5
    } estado_t;

    estado_t        estado, estado_nxt;
    logic [W-1:0]   timer;
    logic [3:0]     lim_q, col_q;
    logic           fim_on, fim_off, hold;
    logic [3:0]     leds_d;
    logic           ocupado_d, pronto_d;

    assign fim_on  = (timer == W'(T_ON - 1));
    assign fim_off = (timer == W'(T_OFF - 1));

`ifdef PAUSA_JOGO_EN
    // congela only matters while colours are being timed
    assign hold = congela && (estado == MOSTRA || estado == PAUSA);
`else
    assign hold = 1'b0;
`endif

    // debug display shows the raw state encoding
    assign db_estado = estado;

    // state register plus registered outputs, so the LEDs never glitch
    always_ff @(posedge clock) begin
        if (reset) begin
            estado  <= IDLE;
            leds    <= '0;
            ocupado <= 1'b0;
            pronto  <= 1'b0;
        end else begin
            estado  <= estado_nxt;
            leds    <= leds_d;
            ocupado <= ocupado_d;
            pronto  <= pronto_d;
        end
    end

    // next-state logic
    always_comb begin
        estado_nxt = estado;
        case (estado)
            IDLE:    if (iniciar) estado_nxt = BUSCA;
            BUSCA:   estado_nxt = CARREGA;
            CARREGA: estado_nxt = MOSTRA;
            MOSTRA:  if (!hold && fim_on) estado_nxt = PAUSA;
            PAUSA:   if (!hold && fim_off)
                         estado_nxt = (endereco == lim_q) ? FIM : BUSCA;
            FIM:     estado_nxt = IDLE;
            default: estado_nxt = IDLE;
        endcase
    end

    // output values for the coming state; on CARREGA->MOSTRA the colour comes
    // straight from the ROM since col_q is loaded on that same edge
    always_comb begin
        leds_d    = '0;
        ocupado_d = (estado_nxt != IDLE);
        pronto_d  = (estado_nxt == FIM);
        if (estado_nxt == MOSTRA)
            leds_d = (estado == CARREGA) ? dado : col_q;
    end

    // datapath: address walk, limit latch, colour capture and interval timer
    always_ff @(posedge clock) begin
        if (reset) begin
            endereco <= '0;
            lim_q    <= '0;
            col_q    <= '0;
            timer    <= '0;
        end else begin
            case (estado)
                IDLE: begin
                    endereco <= '0;
                    if (iniciar) lim_q <= limite;
                end
                CARREGA: begin
                    col_q <= dado;
                    timer <= '0;
                end
                MOSTRA: begin
                    if (!hold) timer <= fim_on ? '0 : timer + 1'b1;
                end
                PAUSA: begin
                    if (!hold) begin
                        if (fim_off) begin
                            timer <= '0;
                            // the last address goes to FIM, so no wrap past 15
                            if (endereco != lim_q) endereco <= endereco + 1'b1;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                end
                FIM: endereco <= '0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_exibe_sequencia.sv
// Directed bench for exibe_sequencia with T_ON=4, T_OFF=2 and a ROM holding
// 1,2,4,8 repeating from address 0.
module tb_exibe_sequencia;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       iniciar = 1'b0;
    logic [3:0] limite = 4'd0;
`ifdef PAUSA_JOGO_EN
    logic       congela = 1'b0;
`endif
    logic [3:0] dado = 4'd0;
    logic [3:0] endereco, leds, db_estado;
    logic       ocupado, pronto;

    int n_asrt = 0;
    int n_fail = 0;

    exibe_sequencia #(.T_ON(4), .T_OFF(2), .W(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .limite    (limite),
`ifdef PAUSA_JOGO_EN
        .congela   (congela),
`endif
        .dado      (dado),
        .endereco  (endereco),
        .leds      (leds),
        .ocupado   (ocupado),
        .pronto    (pronto),
        .db_estado (db_estado)
    );

    always #5 clock = ~clock;

    // synchronous ROM: colour 1 << (addr % 4), one cycle of latency
    always @(posedge clock) dado <= 4'd1 << endereco[1:0];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, " leds"}, 8'(leds), 8'd0);
        chk({tag, " endereco"}, 8'(endereco), 8'd0);
        chk({tag, " ocupado"}, 8'(ocupado), 8'd0);
        chk({tag, " pronto"}, 8'(pronto), 8'd0);
        chk({tag, " db_estado"}, 8'(db_estado), 8'd0);
    endtask

    // Caller sets iniciar=1 before calling. Cycle c=0 is the BUSCA cycle right
    // after the start edge; each colour takes 8 cycles (BUSCA, CARREGA, 4 on,
    // 2 off) and the FIM cycle is c=(lim+1)*8.
    // poke_c: cycle at which iniciar is pulsed and limite changed to 7.
    // rearm: hold iniciar high from the FIM cycle on.
    task automatic play(input int lim, input int poke_c, input bit rearm, input string tag);
        int last, idx, ph, ae;
        logic [3:0] le, de;
        last = (lim + 1) * 8;
        @(posedge clock); #1;
        iniciar = 1'b0;
        for (int c = 0; c <= last; c++) begin
            idx = c / 8;
            ph  = c % 8;
            ae  = (idx > lim) ? lim : idx;
            if (c == last) begin
                le = 4'd0;
                de = 4'd5;
            end else begin
                le = (ph >= 2 && ph <= 5) ? 4'(1 << (idx % 4)) : 4'd0;
                de = (ph < 2) ? 4'(ph + 1) : (ph < 6) ? 4'd3 : 4'd4;
            end
            chk($sformatf("%s c%0d leds", tag, c), 8'(leds), 8'(le));
            chk($sformatf("%s c%0d db_estado", tag, c), 8'(db_estado), 8'(de));
            chk($sformatf("%s c%0d endereco", tag, c), 8'(endereco), 8'(ae));
            chk($sformatf("%s c%0d ocupado", tag, c), 8'(ocupado), 8'd1);
            chk($sformatf("%s c%0d pronto", tag, c), 8'(pronto), 8'(c == last));
            iniciar = (c == poke_c) || (rearm && c == last);
            if (c == poke_c) limite = 4'd7;
            if (c < last) begin
                @(posedge clock); #1;
            end
        end
        @(posedge clock); #1;
        idle_chk({tag, " end"});
    endtask

    initial begin
        // reset held two cycles, then nothing may move without iniciar
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        idle_chk("reset");
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
            idle_chk($sformatf("quiet%0d", i));
        end

        // three colours: 1, 2, 4; pronto in cycle 25 counting from the start
        limite = 4'd2; iniciar = 1'b1;
        play(2, -1, 1'b0, "lim2");

        // single colour
        limite = 4'd0; iniciar = 1'b1;
        play(0, -1, 1'b0, "lim0");

        // full ROM, endereco climbs to 15 with no wrap
        limite = 4'd15; iniciar = 1'b1;
        play(15, -1, 1'b0, "lim15");

        // iniciar pulse and limite=7 during the first MOSTRA are ignored
        limite = 4'd2; iniciar = 1'b1;
        play(2, 3, 1'b0, "ignore");

        // iniciar held across FIM restarts right from the first IDLE cycle
        limite = 4'd0; iniciar = 1'b1;
        play(0, -1, 1'b1, "rearm1");
        play(0, -1, 1'b0, "rearm2");

        // reset during the second MOSTRA aborts the run
        limite = 4'd2; iniciar = 1'b1;
        @(posedge clock); #1;
        iniciar = 1'b0;
        repeat (11) begin
            @(posedge clock); #1;
        end
        chk("abort pre leds", 8'(leds), 8'd2);
        reset = 1'b1;
        @(posedge clock); #1;
        idle_chk("abort");
        reset = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clock); #1;
            chk($sformatf("abort quiet%0d pronto", i), 8'(pronto), 8'd0);
            chk($sformatf("abort quiet%0d leds", i), 8'(leds), 8'd0);
        end

`ifdef PAUSA_JOGO_EN
        // congela high for 10 cycles inside the first MOSTRA: colour 1 stays
        // up for 14 cycles and pronto moves from c=8 to c=18
        limite = 4'd0; iniciar = 1'b1;
        @(posedge clock); #1;
        iniciar = 1'b0;
        for (int c = 0; c <= 19; c++) begin
            chk($sformatf("frz c%0d leds", c), 8'(leds), 8'((c >= 2 && c <= 15) ? 1 : 0));
            chk($sformatf("frz c%0d pronto", c), 8'(pronto), 8'(c == 18));
            chk($sformatf("frz c%0d ocupado", c), 8'(ocupado), 8'(c <= 18));
            congela = (c >= 3 && c <= 12);
            @(posedge clock); #1;
        end
        congela = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
